adder_operand_loader: RTL and testbench

Upstream feeder for the 32-bit ripple adder. It accepts a byte stream on a valid/ready handshake and assembles two 32-bit operands little-endian: 4 bytes for num1, then 4 bytes for num2. It also captures a carry-in bit. It then holds num1/num2/c_in stable, with op_valid asserted, until the consumer acknowledges. Its outputs connect directly to the adder's num1, num2 and C_in inputs.

---
 rtl/adder_operand_loader_if.sv | 30 +++
 rtl/adder_operand_loader.sv | 131 +++++++++++++
 tb/tb_adder_operand_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_operand_loader_if.sv
// Byte-stream input and operand output bundle for the adder operand loader.
// The slave side is the loader itself; the master side is whatever feeds
// bytes and consumes the assembled operands.
interface adder_operand_loader_if #(
    parameter int BYTE_W   = 8,
    parameter int OP_BYTES = 4
);
    localparam int OP_W = BYTE_W * OP_BYTES;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_carry;
    logic              abort;
    logic [OP_W-1:0]   num1;
    logic [OP_W-1:0]   num2;
    logic              c_in;
    logic              op_valid;
    logic              op_ack;

    modport slave (
        input  in_data, in_valid, in_carry, abort, op_ack,
        output in_ready, num1, num2, c_in, op_valid
    );

    modport master (
        output in_data, in_valid, in_carry, abort, op_ack,
        input  in_ready, num1, num2, c_in, op_valid
    );
endinterface

// File: rtl/adder_operand_loader.sv
// Assembles two little-endian operands from a byte stream, captures a carry-in
// with the final byte, and holds everything stable until the consumer acks.
module adder_operand_loader #(
    parameter int BYTE_W   = 8,
    parameter int OP_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_operand_loader_if.slave bus
);
    localparam int OP_W  = BYTE_W * OP_BYTES;
    localparam int CNT_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(OP_BYTES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   num1_q, num1_d;
    logic [OP_W-1:0]   num2_q, num2_d;
    logic              c_in_q, c_in_d;
    logic              op_valid_q, op_valid_d;

    logic              in_ready;
    logic              accept;
    logic [OP_BYTES-1:0] lane_sel;
    logic [OP_W-1:0]   num1_load;
    logic [OP_W-1:0]   num2_load;

    assign in_ready = (state_q != HOLD);
    assign accept   = bus.in_valid && in_ready;

    // Per-lane merge: the lane addressed by the beat count takes the new byte,
    // every other lane keeps its previous contents.
    generate
        for (genvar gi = 0; gi < OP_BYTES; gi++) begin : g_lane
            assign lane_sel[gi] = (cnt_q == CNT_W'(gi));
            assign num1_load[gi*BYTE_W +: BYTE_W] =
                lane_sel[gi] ? bus.in_data : num1_q[gi*BYTE_W +: BYTE_W];
            assign num2_load[gi*BYTE_W +: BYTE_W] =
                lane_sel[gi] ? bus.in_data : num2_q[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Next-state and datapath decode; abort overrides any beat or ack.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num1_d     = num1_q;
        num2_d     = num2_q;
        c_in_d     = c_in_q;
        op_valid_d = op_valid_q;

        if (bus.abort) begin
            state_d    = LOAD_A;
            cnt_d      = '0;
            num1_d     = '0;
            num2_d     = '0;
            c_in_d     = 1'b0;
            op_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        num1_d = num1_load;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        num2_d = num2_load;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_d      = '0;
                            c_in_d     = bus.in_carry;
                            op_valid_d = 1'b1;
                            state_d    = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.op_ack) begin
                        op_valid_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = LOAD_A;
                    end
                end
                default: begin
                    state_d    = LOAD_A;
                    cnt_d      = '0;
                    op_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and operand registers; reset clears any partial or held operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD_A;
            cnt_q      <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            c_in_q     <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            c_in_q     <= c_in_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.num1     = num1_q;
    assign bus.num2     = num2_q;
    assign bus.c_in     = c_in_q;
    assign bus.op_valid = op_valid_q;
endmodule

// File: tb/tb_adder_operand_loader.sv
// Scoreboard bench: expected operations are queued as they are issued and a
// monitor checks each one when op_valid rises.
module tb_adder_operand_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    typedef struct packed {
        logic [31:0] n1;
        logic [31:0] n2;
        logic        c;
        logic [31:0] s;
        logic        co;
    } exp_t;

    exp_t exp_q[$];

    adder_operand_loader_if #(.BYTE_W(8), .OP_BYTES(4)) bus ();

    adder_operand_loader #(.BYTE_W(8), .OP_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic carry);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_carry = carry;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready stayed %b, expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    // bytes = {num2, num1}; beat i is bytes[8i +: 8]
    task automatic load8(input logic [63:0] bytes, input logic carry, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_beat(bytes[8*i +: 8], (i == 7) ? carry : 1'b0);
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_carry = 1'b0;
    endtask

    task automatic push(input logic [31:0] n1, input logic [31:0] n2, input logic c,
                        input logic [31:0] s, input logic co);
        exp_t e;
        e.n1 = n1; e.n2 = n2; e.c = c; e.s = s; e.co = co;
        exp_q.push_back(e);
    endtask

    task automatic ack;
        bus.op_ack = 1'b1;
        @(posedge clk); #1;
        bus.op_ack = 1'b0;
    endtask

    // Monitor: one scoreboard pop per rising op_valid, including the adder result.
    initial begin : monitor
        logic  prev;
        exp_t  e;
        logic [32:0] sum;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.op_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_op: num1=%h num2=%h c_in=%b with empty queue",
                             bus.num1, bus.num2, bus.c_in);
                end else begin
                    e   = exp_q.pop_front();
                    sum = {1'b0, bus.num1} + {1'b0, bus.num2} + {32'd0, bus.c_in};
                    chk("op_num1", {32'd0, bus.num1}, {32'd0, e.n1});
                    chk("op_num2", {32'd0, bus.num2}, {32'd0, e.n2});
                    chk("op_c_in", {63'd0, bus.c_in}, {63'd0, e.c});
                    chk("adder_sum", {32'd0, sum[31:0]}, {32'd0, e.s});
                    chk("adder_cout", {63'd0, sum[32]}, {63'd0, e.co});
                end
            end
            prev = bus.op_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_carry = 1'b0;
        bus.abort    = 1'b0;
        bus.op_ack   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_op_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("rst_num1", {32'd0, bus.num1}, 64'd0);
        chk("rst_num2", {32'd0, bus.num2}, 64'd0);
        chk("rst_c_in", {63'd0, bus.c_in}, 64'd0);

        // Basic operation
        push(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0);
        load8(64'h9ABCDEF0_12345678, 1'b1, 0);
        chk("t1_op_valid_next", {63'd0, bus.op_valid}, 64'd1);
        chk("t1_in_ready_hold", {63'd0, bus.in_ready}, 64'd0);
        ack();
        chk("t1_ack_op_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("t1_ack_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // All ones, held 5 cycles with extra beats offered
        push(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
        load8(64'hFFFFFFFF_FFFFFFFF, 1'b1, 0);
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t2_hold_op_valid", {63'd0, bus.op_valid}, 64'd1);
            chk("t2_hold_num1", {32'd0, bus.num1}, {32'd0, 32'hFFFFFFFF});
            chk("t2_hold_num2", {32'd0, bus.num2}, {32'd0, 32'hFFFFFFFF});
            chk("t2_hold_c_in", {63'd0, bus.c_in}, 64'd1);
            chk("t2_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        ack();

        // Gaps between beats
        push(32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0);
        load8(64'h9ABCDEF0_12345678, 1'b0, 2);
        ack();

        // Abort on the 4th beat of num1
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b0);
        bus.in_data = 8'hDD;
        bus.abort   = 1'b1;
        @(posedge clk); #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_num1", {32'd0, bus.num1}, 64'd0);
        chk("abort_num2", {32'd0, bus.num2}, 64'd0);
        chk("abort_c_in", {63'd0, bus.c_in}, 64'd0);
        chk("abort_op_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        push(32'h04030201, 32'h08070605, 1'b0, 32'h0C0A0806, 1'b0);
        load8(64'h08070605_04030201, 1'b0, 0);
        ack();

        // Stray ack while idle
        bus.op_ack = 1'b1;
        @(posedge clk); #1;
        bus.op_ack = 1'b0;
        chk("stray_ack_op_valid", {63'd0, bus.op_valid}, 64'd0);
        chk("stray_ack_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Back-to-back: ack on first HOLD cycle, stream continues
        push(32'h44332211, 32'h88776655, 1'b0, 32'hCCAA8866, 1'b0);
        push(32'h80000000, 32'h80000000, 1'b1, 32'h00000001, 1'b1);
        t0 = cyc;
        load8(64'h88776655_44332211, 1'b0, 0);
        bus.op_ack = 1'b1;
        load8(64'h80000000_80000000, 1'b1, 0);
        chk("b2b_op_valid", {63'd0, bus.op_valid}, 64'd1);
        @(posedge clk); #1;
        bus.op_ack = 1'b0;
        chk("b2b_cycles", 64'(cyc - t0), 64'd18);
        chk("b2b_done_op_valid", {63'd0, bus.op_valid}, 64'd0);

        // Async reset mid LOAD_B, off the clock edge
        for (int i = 1; i <= 5; i++) send_beat(8'(i), 1'b0);
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_num1", {32'd0, bus.num1}, 64'd0);
        chk("arst_num2", {32'd0, bus.num2}, 64'd0);
        chk("arst_c_in", {63'd0, bus.c_in}, 64'd0);
        chk("arst_op_valid", {63'd0, bus.op_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        push(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        load8(64'h00000001_FFFFFFFF, 1'b0, 0);
        ack();

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
